card_sprite_renderer: RTL and testbench
=======================================

# card_sprite_renderer

- Pixel-pipeline stage directly upstream of a card image memory: 512 × 3-bit words, synchronous read, 1-cycle latency.
- Takes the VGA pixel coordinate stream (256×240) and decides whether the pixel falls inside a 16×32 card placed at a programmable position, optionally scaled 2×.
- Drives the memory read address and consumes the returned color.
- Emits the final pixel color: card color, or the supplied background where the card is absent or transparent.

## Interface

Parameters:

- CARD_W, 16: card width in texels (power of 2)
- CARD_H, 32: card height in texels (power of 2); CARD_W×CARD_H = 512
- X_W, 9: pixel X coordinate width
- Y_W, 8: pixel Y coordinate width

Ports:

- clock  in  1  single system clock; all logic on posedge
- resetN  in  1  asynchronous, active-low reset
- frameStart  in  1  one-cycle pulse at start of vertical blank
- pixValid  in  1  pixX/pixY/bgColor valid this cycle
- pixX  in  X_W  pixel column, 0..255
- pixY  in  Y_W  pixel row, 0..239
- bgColor  in  3  background color for this pixel
- posLoad  in  1  write shadow placement registers
- posX  in  X_W  card top-left column
- posY  in  Y_W  card top-left row
- visible  in  1  card enabled
- scale2x  in  1  1 = each texel covers 2×2 pixels
- rAddr  out  9  card memory read address
- romData  in  3  card memory data, valid one cycle after rAddr
- colorOut  out  3  final pixel color
- colorValid  out  1  colorOut valid
- hit  out  1  colorOut came from an opaque card texel

## Operation

Placement registers:

- Shadow registers {posX, posY, visible, scale2x} are written when posLoad=1.
- Active registers copy from shadow on frameStart. This avoids tearing.
- posLoad and frameStart in the same cycle: active receives the new posLoad values (bypass).
- Reset clears shadow and active to 0; visible=0.

Stage 1 (registers pixValid, inside, bgColor, rAddr):

- w = CARD_W << scale, h = CARD_H << scale.
- dx = pixX − aX and dy = pixY − aY, computed one bit wider.
- inside = aVisible & pixValid & pixX ≥ aX & (pixX < aX + w) & pixY ≥ aY & (pixY < aY + h).
- Sums are computed at X_W+1 / Y_W+1 bits, so a card that is partially off-screen never wraps.
- col = dx >> scale (4 bits), row = dy >> scale (5 bits).
- rAddr = {row, col} when inside, else 0.

Stage 2: pipeline registers carry valid, inside and bgColor alongside the memory read.

Stage 3 (output):

- colorValid = valid.
- opaque = inside & (romData ≠ 3'b000). Code 000 means transparent.
- colorOut = opaque ? romData : bgColor.
- hit = opaque.
- When valid=0: colorOut holds its previous value and hit=0.

## Timing

- Pixel presented in cycle n:
  - rAddr updates at edge n.
  - Memory data is returned after edge n+1.
  - colorOut/colorValid/hit are valid in cycle n+3. Fixed 3-cycle latency.
- Throughput: one pixel per cycle, no stalls, no backpressure.
- pixValid gaps propagate as colorValid=0 exactly 3 cycles later.
- Active placement changes take effect for pixels presented in the cycle after frameStart.
- Reset (asynchronous, any cycle, including mid-line):
  - rAddr=0, colorOut=0, colorValid=0, hit=0.
  - All pipeline valid/inside bits are cleared; no partial pixels emerge after release.
- All outputs are registered.

## Test plan

- Reset: assert resetN=0 mid-stream → outputs 0 immediately; after release, colorValid stays 0 until 3 cycles after the first pixValid.
- Basic hit: pos (10,20), visible, no scale, frameStart.
  - Pixel (10,20) → rAddr 0. Return romData=5 → colorOut=5, hit=1 at n+3.
  - Pixel (25,51) → rAddr 511.
- Outside / transparent, bgColor=2:
  - Pixel (26,20) → colorOut=2, hit=0.
  - Pixel inside with romData=0 → colorOut=2, hit=0.
- Scale: pos (10,20), scale2x=1.
  - Pixel (41,83) → rAddr 511.
  - Pixel (42,20) → outside.
  - Pixels (10,20) and (11,21) → both rAddr 0.
- Shadow: posLoad (100,100) mid-frame → pixel (10,20) still hits; after frameStart it misses and (100,100) hits. posLoad together with frameStart → new values apply immediately.
- Edge: pos (250,230).
  - Pixel (255,239) → inside, rAddr {5'd9, 4'd5} = 149.
  - Pixel (0,0) → outside (no wrap).
  - visible=0 → never hit.

Source files
------------

// File: rtl/card_sprite_renderer.sv
// Card sprite pixel stage: tests each pixel against a 16x32 (optionally 2x) card,
// drives the card memory address and merges the returned texel over the background.
module card_sprite_renderer #(
   parameter int CARD_W = 16,
   parameter int CARD_H = 32,
   parameter int X_W    = 9,
   parameter int Y_W    = 8
) (
   input  logic           clock,
   input  logic           resetN,
   input  logic           frameStart,
   input  logic           pixValid,
   input  logic [X_W-1:0] pixX,
   input  logic [Y_W-1:0] pixY,
   input  logic [2:0]     bgColor,
   input  logic           posLoad,
   input  logic [X_W-1:0] posX,
   input  logic [Y_W-1:0] posY,
   input  logic           visible,
   input  logic           scale2x,
   output logic [8:0]     rAddr,
   input  logic [2:0]     romData,
   output logic [2:0]     colorOut,
   output logic           colorValid,
   output logic           hit
);

   localparam int COL_W = $clog2(CARD_W);
   localparam int ROW_W = $clog2(CARD_H);
   localparam logic [X_W:0] W_1X = (X_W+1)'(CARD_W);
   localparam logic [X_W:0] W_2X = (X_W+1)'(2 * CARD_W);
   localparam logic [Y_W:0] H_1X = (Y_W+1)'(CARD_H);
   localparam logic [Y_W:0] H_2X = (Y_W+1)'(2 * CARD_H);

   logic [X_W-1:0] sh_x_q, sh_x_d, act_x_q, act_x_d;
   logic [Y_W-1:0] sh_y_q, sh_y_d, act_y_q, act_y_d;
   logic           sh_vis_q, sh_vis_d, act_vis_q, act_vis_d;
   logic           sh_sc_q, sh_sc_d, act_sc_q, act_sc_d;

   logic           s1_valid_q, s1_valid_d, s1_inside_q, s1_inside_d;
   logic [2:0]     s1_bg_q, s1_bg_d;
   logic [8:0]     raddr_q, raddr_d;
   logic           s2_valid_q, s2_valid_d, s2_inside_q, s2_inside_d;
   logic [2:0]     s2_bg_q, s2_bg_d;
   logic [2:0]     color_q, color_d;
   logic           cvalid_q, cvalid_d;
   logic           hit_q, hit_d;

   logic [X_W:0]   x_ext, ax_ext, x_end, dx, dx_sc;
   logic [Y_W:0]   y_ext, ay_ext, y_end, dy, dy_sc;
   logic           in_x, in_y, opaque;
   logic           unused_bits;

   // Placement: the shadow's next value doubles as the frameStart source, so a
   // posLoad in the same cycle as frameStart lands in the active set directly.
   always_comb begin
      sh_x_d   = sh_x_q;
      sh_y_d   = sh_y_q;
      sh_vis_d = sh_vis_q;
      sh_sc_d  = sh_sc_q;
      if (posLoad) begin
         sh_x_d   = posX;
         sh_y_d   = posY;
         sh_vis_d = visible;
         sh_sc_d  = scale2x;
      end
      act_x_d   = act_x_q;
      act_y_d   = act_y_q;
      act_vis_d = act_vis_q;
      act_sc_d  = act_sc_q;
      if (frameStart) begin
         act_x_d   = sh_x_d;
         act_y_d   = sh_y_d;
         act_vis_d = sh_vis_d;
         act_sc_d  = sh_sc_d;
      end
   end

   // Stage 1: one-bit-wider bounds so a card hanging off the screen edge never wraps.
   always_comb begin
      x_ext  = {1'b0, pixX};
      ax_ext = {1'b0, act_x_q};
      y_ext  = {1'b0, pixY};
      ay_ext = {1'b0, act_y_q};
      x_end  = ax_ext + (act_sc_q ? W_2X : W_1X);
      y_end  = ay_ext + (act_sc_q ? H_2X : H_1X);
      dx     = x_ext - ax_ext;
      dy     = y_ext - ay_ext;
      dx_sc  = act_sc_q ? (dx >> 1) : dx;
      dy_sc  = act_sc_q ? (dy >> 1) : dy;
      in_x   = (x_ext >= ax_ext) && (x_ext < x_end);
      in_y   = (y_ext >= ay_ext) && (y_ext < y_end);
      s1_inside_d = act_vis_q & pixValid & in_x & in_y;
      s1_valid_d  = pixValid;
      s1_bg_d     = bgColor;
      raddr_d     = s1_inside_d ? {dy_sc[ROW_W-1:0], dx_sc[COL_W-1:0]} : 9'd0;
   end

   assign unused_bits = ^{dx_sc[X_W:COL_W], dy_sc[Y_W:ROW_W]};

   // Stages 2 and 3: carry pixel context past the memory, then merge.
   always_comb begin
      s2_valid_d  = s1_valid_q;
      s2_inside_d = s1_inside_q;
      s2_bg_d     = s1_bg_q;
      opaque      = s2_inside_q & (romData != 3'b000);
      cvalid_d    = s2_valid_q;
      hit_d       = s2_valid_q & opaque;
      color_d     = color_q;
      if (s2_valid_q) begin
         color_d = opaque ? romData : s2_bg_q;
      end
   end

   always_ff @(posedge clock or negedge resetN) begin
      if (!resetN) begin
         sh_x_q      <= '0;
         sh_y_q      <= '0;
         sh_vis_q    <= 1'b0;
         sh_sc_q     <= 1'b0;
         act_x_q     <= '0;
         act_y_q     <= '0;
         act_vis_q   <= 1'b0;
         act_sc_q    <= 1'b0;
         s1_valid_q  <= 1'b0;
         s1_inside_q <= 1'b0;
         s1_bg_q     <= 3'd0;
         raddr_q     <= 9'd0;
         s2_valid_q  <= 1'b0;
         s2_inside_q <= 1'b0;
         s2_bg_q     <= 3'd0;
         color_q     <= 3'd0;
         cvalid_q    <= 1'b0;
         hit_q       <= 1'b0;
      end else begin
         sh_x_q      <= sh_x_d;
         sh_y_q      <= sh_y_d;
         sh_vis_q    <= sh_vis_d;
         sh_sc_q     <= sh_sc_d;
         act_x_q     <= act_x_d;
         act_y_q     <= act_y_d;
         act_vis_q   <= act_vis_d;
         act_sc_q    <= act_sc_d;
         s1_valid_q  <= s1_valid_d;
         s1_inside_q <= s1_inside_d;
         s1_bg_q     <= s1_bg_d;
         raddr_q     <= raddr_d;
         s2_valid_q  <= s2_valid_d;
         s2_inside_q <= s2_inside_d;
         s2_bg_q     <= s2_bg_d;
         color_q     <= color_d;
         cvalid_q    <= cvalid_d;
         hit_q       <= hit_d;
      end
   end

   assign rAddr      = raddr_q;
   assign colorOut   = color_q;
   assign colorValid = cvalid_q;
   assign hit        = hit_q;

endmodule

// File: tb/tb_card_sprite_renderer.sv
// Bench for card_sprite_renderer: directed pixels with literal expectations, then
// random placement/pixel traffic against a rectangle-and-divide reference model.
module tb_card_sprite_renderer;

   localparam int X_W   = 9;
   localparam int Y_W   = 8;
   localparam int DEPTH = 8192;

   logic           clock = 1'b0;
   logic           resetN = 1'b1;
   logic           frameStart = 1'b0;
   logic           pixValid = 1'b0;
   logic [X_W-1:0] pixX = '0;
   logic [Y_W-1:0] pixY = '0;
   logic [2:0]     bgColor = 3'd0;
   logic           posLoad = 1'b0;
   logic [X_W-1:0] posX = '0;
   logic [Y_W-1:0] posY = '0;
   logic           visible = 1'b0;
   logic           scale2x = 1'b0;
   logic [8:0]     rAddr;
   logic [2:0]     romData = 3'd0;
   logic [2:0]     colorOut;
   logic           colorValid;
   logic           hit;

   card_sprite_renderer #(.CARD_W(16), .CARD_H(32), .X_W(X_W), .Y_W(Y_W)) dut (
      .clock(clock), .resetN(resetN), .frameStart(frameStart), .pixValid(pixValid),
      .pixX(pixX), .pixY(pixY), .bgColor(bgColor), .posLoad(posLoad), .posX(posX),
      .posY(posY), .visible(visible), .scale2x(scale2x), .rAddr(rAddr),
      .romData(romData), .colorOut(colorOut), .colorValid(colorValid), .hit(hit)
   );

   // ---------------- clock / memory ----------------
   always #5 clock = ~clock;

   logic [2:0] mem [0:511];
   always @(posedge clock) romData <= mem[rAddr];

   int cyc = 0;
   always @(posedge clock) cyc++;

   // ---------------- reference model state ----------------
   int  sh_x = 0, sh_y = 0, act_x = 0, act_y = 0;
   bit  sh_v = 0, sh_s = 0, act_v = 0, act_s = 0;

   logic [8:0] e_addr [DEPTH];
   bit         e_ov   [DEPTH];
   bit         e_hit  [DEPTH];
   logic [2:0] e_col  [DEPTH];
   bit         pa_en  [DEPTH];
   logic [8:0] pa     [DEPTH];
   bit         po_en  [DEPTH];
   logic [2:0] pcol   [DEPTH];
   bit         phit   [DEPTH];

   bit         pin_a_en = 0, pin_o_en = 0, pin_h = 0;
   int         pin_a = 0, pin_c = 0;

   int n_checks = 0;
   int n_fail   = 0;

   task automatic chk(input string nm, input int got, input int exp);
      n_checks++;
      if (got != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, got, exp, cyc);
      end
   endtask

   // One pixel clock: predict this cycle's pixel, update placement, advance.
   task automatic tick();
      int  c, px, py, sc, a;
      bit  ins, opq;
      c   = cyc;
      px  = int'(pixX);
      py  = int'(pixY);
      sc  = act_s ? 2 : 1;
      ins = resetN && pixValid && act_v &&
            px >= act_x && px < act_x + 16 * sc &&
            py >= act_y && py < act_y + 32 * sc;
      a   = ins ? ((py - act_y) / sc) * 16 + (px - act_x) / sc : 0;
      opq = ins && (mem[a] != 3'd0);
      e_addr[c+1] = 9'(a);
      e_ov[c+3]   = resetN && pixValid;
      e_hit[c+3]  = opq;
      e_col[c+3]  = opq ? mem[a] : bgColor;
      if (pin_a_en) begin
         pa_en[c+1] = 1;
         pa[c+1]    = 9'(pin_a);
      end
      if (pin_o_en) begin
         po_en[c+3] = 1;
         pcol[c+3]  = 3'(pin_c);
         phit[c+3]  = pin_h;
      end
      pin_a_en = 0;
      pin_o_en = 0;
      if (resetN) begin
         if (frameStart) begin
            if (posLoad) begin
               act_x = int'(posX); act_y = int'(posY); act_v = visible; act_s = scale2x;
            end else begin
               act_x = sh_x; act_y = sh_y; act_v = sh_v; act_s = sh_s;
            end
         end
         if (posLoad) begin
            sh_x = int'(posX); sh_y = int'(posY); sh_v = visible; sh_s = scale2x;
         end
      end
      @(posedge clock);
      #1;
      pixValid   = 1'b0;
      posLoad    = 1'b0;
      frameStart = 1'b0;
   endtask

   // ---------------- driver tasks ----------------
   task automatic pix(input int x, input int y, input int bg);
      pixX     = X_W'(x);
      pixY     = Y_W'(y);
      bgColor  = 3'(bg);
      pixValid = 1'b1;
      tick();
   endtask

   task automatic place(input int x, input int y, input bit v, input bit s, input bit fs);
      posLoad    = 1'b1;
      posX       = X_W'(x);
      posY       = Y_W'(y);
      visible    = v;
      scale2x    = s;
      frameStart = fs;
      tick();
   endtask

   task automatic fstart();
      frameStart = 1'b1;
      tick();
   endtask

   task automatic idle(input int n);
      repeat (n) tick();
   endtask

   task automatic pin_addr(input int a);
      pin_a_en = 1;
      pin_a    = a;
   endtask

   task automatic pin_out(input int col, input bit h);
      pin_o_en = 1;
      pin_c    = col;
      pin_h    = h;
   endtask

   // Asynchronous reset in the middle of a cycle; everything in flight is dropped.
   task automatic do_reset();
      resetN = 1'b0;
      for (int k = cyc; k < cyc + 4; k++) begin
         e_addr[k] = 9'd0;
         e_ov[k]   = 0;
         e_hit[k]  = 0;
      end
      sh_x = 0; sh_y = 0; sh_v = 0; sh_s = 0;
      act_x = 0; act_y = 0; act_v = 0; act_s = 0;
      tick();
      tick();
      resetN = 1'b1;
   endtask

   // ---------------- compare process ----------------
   logic [2:0] last_col = 3'd0;

   initial begin
      forever begin
         @(negedge clock);
         if (!resetN) begin
            chk("rst_raddr", int'(rAddr), 0);
            chk("rst_color", int'(colorOut), 0);
            chk("rst_valid", int'(colorValid), 0);
            chk("rst_hit", int'(hit), 0);
            last_col = 3'd0;
         end else if (cyc < DEPTH) begin
            chk("raddr", int'(rAddr), int'(e_addr[cyc]));
            chk("color_valid", int'(colorValid), int'(e_ov[cyc]));
            if (e_ov[cyc]) last_col = e_col[cyc];
            chk("color_out", int'(colorOut), int'(last_col));
            chk("hit", int'(hit), int'(e_ov[cyc] && e_hit[cyc]));
            if (pa_en[cyc]) chk("pin_raddr", int'(rAddr), int'(pa[cyc]));
            if (po_en[cyc]) begin
               chk("pin_color", int'(colorOut), int'(pcol[cyc]));
               chk("pin_hit", int'(hit), int'(phit[cyc]));
            end
         end
      end
   end

   // ---------------- stimulus ----------------
   initial begin
      int x, y;
      for (int k = 0; k < DEPTH; k++) begin
         e_addr[k] = 9'd0;
         e_col[k]  = 3'd0;
         pa[k]     = 9'd0;
         pcol[k]   = 3'd0;
      end
      for (int k = 0; k < 512; k++) mem[k] = 3'((k % 7) + 1);
      mem[0]   = 3'd5;
      mem[1]   = 3'd0;
      mem[511] = 3'd6;
      mem[149] = 3'd3;

      #2 resetN = 1'b0;
      repeat (3) @(posedge clock);
      #1 resetN = 1'b1;
      idle(2);

      // basic hit, outside, transparent
      place(10, 20, 1, 0, 1);
      pin_addr(0);   pin_out(5, 1); pix(10, 20, 2);
      pin_addr(511); pin_out(6, 1); pix(25, 51, 1);
      pin_addr(0);   pin_out(2, 0); pix(26, 20, 2);
      pin_addr(1);   pin_out(2, 0); pix(11, 20, 2);
      idle(1);

      // reset mid-stream with pixels in flight
      pix(12, 21, 4);
      pix(13, 22, 4);
      do_reset();
      idle(2);
      pix(10, 20, 4);
      idle(3);

      // 2x scale
      place(10, 20, 1, 1, 1);
      pin_addr(511); pin_out(6, 1); pix(41, 83, 1);
      pin_addr(0);   pin_out(1, 0); pix(42, 20, 1);
      pin_addr(0);   pin_out(5, 1); pix(10, 20, 0);
      pin_addr(0);   pin_out(5, 1); pix(11, 21, 0);

      // shadow vs active placement
      place(10, 20, 1, 0, 1);
      place(100, 100, 1, 0, 0);
      pin_out(5, 1); pix(10, 20, 3);
      fstart();
      pin_addr(0); pin_out(3, 0); pix(10, 20, 3);
      pin_addr(0); pin_out(5, 1); pix(100, 100, 3);
      place(10, 20, 1, 0, 1);
      pin_addr(0); pin_out(5, 1); pix(10, 20, 3);

      // screen edge and visibility
      place(250, 230, 1, 0, 1);
      pin_addr(149); pin_out(3, 1); pix(255, 239, 7);
      pin_addr(0);   pin_out(7, 0); pix(0, 0, 7);
      place(250, 230, 0, 0, 1);
      pin_addr(0);   pin_out(7, 0); pix(255, 239, 7);
      idle(4);

      // random traffic
      for (int k = 0; k < 512; k++)
         mem[k] = ($urandom_range(0, 3) == 0) ? 3'd0 : 3'($urandom_range(1, 7));
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 15) == 0) begin
            posLoad = 1'b1;
            posX    = X_W'($urandom_range(0, 255));
            posY    = Y_W'($urandom_range(0, 239));
            visible = ($urandom_range(0, 4) != 0);
            scale2x = 1'($urandom_range(0, 1));
         end
         if ($urandom_range(0, 23) == 0) frameStart = 1'b1;
         if ($urandom_range(0, 1) == 0) begin
            x = act_x + $urandom_range(0, 40) - 4;
            y = act_y + $urandom_range(0, 72) - 4;
         end else begin
            x = $urandom_range(0, 255);
            y = $urandom_range(0, 239);
         end
         if (x < 0) x = 0;
         if (x > 255) x = 255;
         if (y < 0) y = 0;
         if (y > 239) y = 239;
         pixX     = X_W'(x);
         pixY     = Y_W'(y);
         bgColor  = 3'($urandom_range(0, 7));
         pixValid = ($urandom_range(0, 6) != 0);
         tick();
      end
      idle(5);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
